// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// No logic of its own: state encoding, owner ids, default widths.
// Backpressure is not applicable here; see mem_arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_LAT_DEF   = 1;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_E = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between CPU (C) and external (E) ports; tie-break set by MEM_ARB_RR_EN.
// Latency: purely combinational, result is used in the same IDLE cycle.
// Backpressure: none here; losing requester simply stays pending and stalls.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic               c_req,
    input  logic               e_req,
    input  logic               e_lock,
    input  logic               last_owner,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               grant_vld,
    output logic               grant_owner
);

    logic lock_ok;

    always_comb begin
        lock_ok     = e_lock && (last_owner == OWN_E) && (burst_cnt < BURST_W'(MAX_BURST));
        grant_vld   = c_req | e_req;
        grant_owner = OWN_C;
        if (lock_ok && e_req) begin
            grant_owner = OWN_E;
        end else if (e_req && !c_req) begin
            grant_owner = OWN_E;
        end else if (e_req && c_req) begin
`ifdef MEM_ARB_RR_EN
            grant_owner = (last_owner == OWN_C) ? OWN_E : OWN_C;
`else
            grant_owner = OWN_C;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises C/E accesses to the single-ported data memory (tie-break via MEM_ARB_RR_EN).
// Latency: request sampled in IDLE at N, memory strobe at N+1, ack at N+2+MEM_LAT.
// Backpressure: one access in flight; other requesters wait with c_stall raised.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_LAT   = MEM_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              e_req,
    input  logic              e_we,
    input  logic              e_lock,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_ack,
    output logic [DATA_W-1:0] e_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t         state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [BURST_W-1:0] burst_cnt_q;
    logic               last_owner_q;
    logic               own_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               grant_vld;
    logic               grant_owner;
    logic               grant_fire;
    logic               lat_last;
    logic               rdata_capture;

    mem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) u_pick (
        .c_req       (c_req),
        .e_req       (e_req),
        .e_lock      (e_lock),
        .last_owner  (last_owner_q),
        .burst_cnt   (burst_cnt_q),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    assign grant_fire      = (state_q == ST_IDLE) && grant_vld;
    assign lat_last        = (lat_cnt_q == LAT_W'(MEM_LAT - 1));
    assign rdata_capture   = (state_q == ST_WAIT) && lat_last && !we_q;
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign c_stall         = c_req & ~c_ack;

    always_comb begin
        state_d      = state_q;
        mem_read     = 1'b0;
        mem_write_en = 1'b0;
        c_ack        = 1'b0;
        e_ack        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d      = ST_WAIT;
                mem_write_en = we_q;
                mem_read     = ~we_q;
            end
            ST_WAIT: begin
                if (lat_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                c_ack   = (own_q == OWN_C);
                e_ack   = (own_q == OWN_E);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            last_owner_q <= OWN_E;
            own_q        <= OWN_C;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            c_rdata      <= '0;
            e_rdata      <= '0;
        end else begin
            state_q <= state_d;

            // Lock release clears the run immediately; C grants also end it.
            if (!e_lock) begin
                burst_cnt_q <= '0;
            end else if (grant_fire && grant_owner == OWN_E &&
                         burst_cnt_q < BURST_W'(MAX_BURST)) begin
                burst_cnt_q <= burst_cnt_q + BURST_W'(1);
            end
            if (grant_fire && grant_owner == OWN_C) burst_cnt_q <= '0;

            if (grant_fire) begin
                own_q        <= grant_owner;
                last_owner_q <= grant_owner;
                we_q         <= (grant_owner == OWN_E) ? e_we    : c_we;
                addr_q       <= (grant_owner == OWN_E) ? e_addr  : c_addr;
                wdata_q      <= (grant_owner == OWN_E) ? e_wdata : c_wdata;
            end

            if (state_q == ST_ISSUE) begin
                lat_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            end

            if (rdata_capture) begin
                if (own_q == OWN_C) c_rdata <= mem_read_data;
                else                e_rdata <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed literal checks.
// A second instance with MEM_LAT=3 checks read-data capture timing.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LAT  = 1;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        e_req = 1'b0, e_we = 1'b0, e_lock = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic        c_ack, c_stall, e_ack, mem_write_en, mem_read;
    logic [31:0] c_rdata, e_rdata, mem_access_addr, mem_write_data;
    logic [31:0] mem_read_data = '0;

    logic        c3_ack, c3_stall, e3_ack, m3_we, m3_rd;
    logic [31:0] c3_rdata, e3_rdata, m3_addr, m3_wdata;
    logic [31:0] m3_rdata = '0;
    logic        z1 = 1'b0;
    logic [31:0] z32 = '0;
    logic        m3_force = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_ack(e_ack), .e_rdata(e_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_BURST(MAXB)) dut3 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c3_ack), .c_rdata(c3_rdata), .c_stall(c3_stall),
        .e_req(z1), .e_we(z1), .e_lock(z1), .e_addr(z32), .e_wdata(z32),
        .e_ack(e3_ack), .e_rdata(e3_rdata),
        .mem_access_addr(m3_addr), .mem_write_data(m3_wdata),
        .mem_write_en(m3_we), .mem_read(m3_rd), .mem_read_data(m3_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Memory seen by the DUT, and the model's own view of what memory should hold.
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction
    function automatic logic [31:0] rd_dmem(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] rd_rmem(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dmem[a] = v;
        rmem[a] = v;
    endtask

    // Reference model state: at most one access in flight.
    bit          chk_on = 0;
    bit          txn_vld = 0, txn_owner = 0, txn_we = 0;
    logic [31:0] txn_addr = '0, txn_wdata = '0;
    int          txn_issue = -1, txn_ack = -1, next_free = 0;
    bit          last_owner = 1;
    int          burst = 0;
    logic [31:0] exp_c_rdata = '0, exp_e_rdata = '0;
    bit          pend_vld = 0;
    logic [31:0] pend_addr = '0;
    int          pend_cyc = 0;

    always @(negedge clk) begin
        bit exp_rd, exp_wr, exp_cack, exp_eack, lock_ok, w, granted;
        // memory stand-in: data valid exactly LAT cycles after the read strobe
        if (mem_write_en === 1'b1) dmem[mem_access_addr] = mem_write_data;
        if (mem_read === 1'b1) begin
            pend_vld = 1; pend_addr = mem_access_addr; pend_cyc = cyc;
        end
        mem_read_data = (pend_vld && cyc == pend_cyc + LAT) ? rd_dmem(pend_addr) : $urandom;
        m3_rdata      = m3_force ? 32'hCAFE_F00D : $urandom;

        exp_rd   = txn_vld && cyc == txn_issue && !txn_we;
        exp_wr   = txn_vld && cyc == txn_issue && txn_we;
        exp_cack = txn_vld && cyc == txn_ack && txn_owner == 0;
        exp_eack = txn_vld && cyc == txn_ack && txn_owner == 1;
        if (exp_wr) rmem[txn_addr] = txn_wdata;
        if (txn_vld && cyc == txn_ack && !txn_we) begin
            if (txn_owner == 0) exp_c_rdata = rd_rmem(txn_addr);
            else                exp_e_rdata = rd_rmem(txn_addr);
        end
        if (chk_on) begin
            chk("mem_read", mem_read, exp_rd);
            chk("mem_write_en", mem_write_en, exp_wr);
            if (exp_rd || exp_wr) chk("mem_access_addr", mem_access_addr, txn_addr);
            if (exp_wr) chk("mem_write_data", mem_write_data, txn_wdata);
            chk("c_ack", c_ack, exp_cack);
            chk("e_ack", e_ack, exp_eack);
            chk("c_rdata", c_rdata, exp_c_rdata);
            chk("e_rdata", e_rdata, exp_e_rdata);
            chk("c_stall", c_stall, c_req & ~exp_cack);
        end
        if (txn_vld && cyc == txn_ack) txn_vld = 0;

        granted = 0;
        w = 0;
        if (reset) begin
            txn_vld = 0; next_free = cyc + 1; last_owner = 1; burst = 0;
            exp_c_rdata = '0; exp_e_rdata = '0; chk_on = 1;
        end else begin
            lock_ok = e_lock && last_owner == 1 && burst < MAXB;
            if (cyc >= next_free && (c_req || e_req)) begin
                granted = 1;
                if (e_req && lock_ok)       w = 1;
                else if (c_req && !e_req)   w = 0;
                else if (e_req && !c_req)   w = 1;
                else begin
`ifdef MEM_ARB_RR_EN
                    w = !last_owner;
`else
                    w = 0;
`endif
                end
                txn_vld   = 1;
                txn_owner = w;
                txn_we    = w ? e_we : c_we;
                txn_addr  = w ? e_addr : c_addr;
                txn_wdata = w ? e_wdata : c_wdata;
                txn_issue = cyc + 1;
                txn_ack   = cyc + 2 + LAT;
                next_free = cyc + 3 + LAT;
                last_owner = w;
            end
            if (!e_lock)                burst = 0;
            else if (granted && w == 1) burst = (burst < MAXB) ? burst + 1 : MAXB;
            if (granted && w == 0)      burst = 0;
        end
    end

    // Ack history for the requester drivers and for grant-order checks.
    bit c_ack_s = 0, e_ack_s = 0, log_en = 0;
    int ack_log[$];
    always @(negedge clk) begin
        c_ack_s = (c_ack === 1'b1);
        e_ack_s = (e_ack === 1'b1);
        if (log_en) begin
            if (c_ack === 1'b1) ack_log.push_back(0);
            if (e_ack === 1'b1) ack_log.push_back(1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input int p_c, input int p_e, input int p_lock);
        step();
        if (c_req && c_ack_s) c_req = 0;
        if (e_req && e_ack_s) e_req = 0;
        if (!c_req && $urandom_range(0, 99) < p_c) begin
            c_req = 1; c_we = 1'($urandom_range(0, 1));
            c_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; c_wdata = $urandom;
        end
        if (!e_req && $urandom_range(0, 99) < p_e) begin
            e_req = 1; e_we = 1'($urandom_range(0, 1));
            e_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; e_wdata = $urandom;
        end
        if ($urandom_range(0, 99) < p_lock) e_lock = ~e_lock;
    endtask

    task automatic idle(input int n);
        c_req = 0; e_req = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        step();
        reset = 1; c_req = 0; e_req = 0; e_lock = 0; c_we = 0; e_we = 0;
        step();
        step();
        reset = 0;
    endtask

    task automatic check_order(input string tag, input int n, input int exp[5]);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_grant%0d", tag, i),
                (i < ack_log.size()) ? 32'(ack_log[i]) : 32'd9, 32'(exp[i]));
    endtask

    initial begin
        int exp_order[5];
        preload(32'h10, 32'hDEAD_BEEF);
        preload(32'h30, 32'h1234_5678);
        step(); step(); step();
        reset = 0;
        @(negedge clk);
        chk("rst_c_ack", c_ack, 0);
        chk("rst_e_ack", e_ack, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_e_rdata", e_rdata, 0);
        chk("rst_strobes", {mem_read, mem_write_en}, 0);
        chk("rst_mem_addr", mem_access_addr, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        idle(2);

        // C read alone; the MEM_LAT=3 instance sees the same request
        step();
        c_req = 1; c_we = 0; c_addr = 32'h10; c_wdata = '0;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) step();
            if (i == 4) c_req = 0;
            m3_force = (i == 4);
            @(negedge clk);
            case (i)
                0: chk("cread_stall0", c_stall, 1);
                1: begin
                    chk("cread_mem_read", mem_read, 1);
                    chk("cread_addr", mem_access_addr, 32'h10);
                    chk("cread_stall1", c_stall, 1);
                    chk("lat3_mem_read", m3_rd, 1);
                end
                2: begin
                    chk("cread_stall2", c_stall, 1);
                    chk("cread_noack2", c_ack, 0);
                end
                3: begin
                    chk("cread_ack", c_ack, 1);
                    chk("cread_rdata", c_rdata, 32'hDEAD_BEEF);
                    chk("lat3_noack3", c3_ack, 0);
                end
                5: begin
                    chk("lat3_ack", c3_ack, 1);
                    chk("lat3_rdata", c3_rdata, 32'hCAFE_F00D);
                end
                default: ;
            endcase
        end
        step();
        m3_force = 0;
        idle(8);

        // E write
        step();
        e_req = 1; e_we = 1; e_addr = 32'h20; e_wdata = 32'h55; e_lock = 0;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (i == 1) begin
                chk("ewr_we", mem_write_en, 1);
                chk("ewr_rd", mem_read, 0);
                chk("ewr_addr", mem_access_addr, 32'h20);
                chk("ewr_data", mem_write_data, 32'h55);
            end
            if (i == 2) chk("ewr_we_once", mem_write_en, 0);
            if (i == 3) begin
                chk("ewr_ack", e_ack, 1);
                chk("ewr_rdata_kept", e_rdata, 0);
            end
        end
        idle(8);

        // Reset during WAIT of a C read, then a fresh request
        step();
        c_req = 1; c_we = 0; c_addr = 32'h30;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            if (i == 2) reset = 1;
            if (i == 3) begin reset = 0; c_req = 0; end
            if (i == 4) c_req = 1;
            @(negedge clk);
            if (i >= 2 && i <= 6) chk($sformatf("rstw_noack%0d", i), c_ack, 0);
            if (i == 3) begin
                chk("rstw_rdata0", c_rdata, 0);
                chk("rstw_strobe0", mem_read, 0);
                chk("rstw_addr0", mem_access_addr, 0);
            end
            if (i == 5) chk("rstw_reissue", mem_read, 1);
            if (i == 7) begin
                chk("rstw_ack", c_ack, 1);
                chk("rstw_rdata", c_rdata, 32'h1234_5678);
            end
        end
        idle(8);

        // Tie: both ports request continuously
        do_reset();
        ack_log.delete();
        log_en = 1;
        repeat (4 * (3 + LAT) + 2) drive_cycle(100, 100, 0);
        log_en = 0;
        idle(8);
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        check_order("tie", 4, exp_order);

        // Lock: E owns first, burst limited to MAXB
        do_reset();
        e_lock = 1;
        ack_log.delete();
        log_en = 1;
        repeat (5 * (3 + LAT) + 2) drive_cycle(100, 100, 0);
        log_en = 0;
        idle(8);
        e_lock = 0;
        exp_order = '{1, 1, 1, 1, 0};
        check_order("lock", 5, exp_order);

        // Randomised traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive_cycle(40, 40, 10);
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 0;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single-ported data memory. It shares the memory between two requesters: the CPU load/store path (port C) and an external loader/debug port (port E). It serialises accesses through a four-state FSM, returns read data with a one-cycle ack pulse, and produces the CPU stall signal. It sits between the `mips` datapath (ALU address, `reg_read_data_2` write data, `mem_read`/`mem_write` strobes) and `data_memory`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from issue to valid `mem_read_data` (≥1)
- `MAX_BURST`, 4, max consecutive locked E grants while C is waiting (≥1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `c_req`, `c_we`  in  1 each  CPU request, write enable
- `c_addr`  in  ADDR_W  CPU address
- `c_wdata`  in  DATA_W  CPU write data
- `c_ack`  out  1  one-cycle completion pulse
- `c_rdata`  out  DATA_W  read data, valid with `c_ack`
- `c_stall`  out  1  `c_req & ~c_ack` (combinational)
- `e_req`, `e_we`, `e_lock`  in  1 each  ext request, write enable, burst lock
- `e_addr`  in  ADDR_W  ext address
- `e_wdata`  in  DATA_W  ext write data
- `e_ack`  out  1  one-cycle completion pulse
- `e_rdata`  out  DATA_W  read data, valid with `e_ack`
- `mem_access_addr`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_write_en`, `mem_read`  out  1 each  memory strobes
- `mem_read_data`  in  DATA_W  memory read data

## Operation
- **FSM states:** IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE:**
  - If any request is present, pick a winner and latch its `addr`, `wdata`, `we` and owner into registers.
  - Go to ISSUE. Stay in IDLE otherwise.
- **ISSUE (exactly 1 cycle):**
  - Drive `mem_*` from the latched registers.
  - `mem_write_en = we`, `mem_read = ~we`.
  - Strobes are 0 in every other state.
- **WAIT:**
  - Lasts `MEM_LAT` cycles, counted by the latency counter.
  - On the last WAIT cycle, capture `mem_read_data` into the rdata register (reads only).
- **DONE (1 cycle):** pulse the owner's ack. Its rdata output holds the captured value and is stable until the next ack on that port.
- **Arbitration, in priority order:**
  1. Lock: if `e_lock` is high, the last owner was E and `burst_cnt < MAX_BURST`, E wins when `e_req` is high.
  2. Otherwise, if only one port requests, that port wins.
  3. Both request: the tie-break depends on `MEM_ARB_RR_EN` (see Configuration).
- **`burst_cnt`:**
  - Increments on each E grant while `e_lock` is high.
  - Clears on any C grant and on any cycle with `e_lock` low.
  - Saturates at `MAX_BURST`; once saturated, C wins if requesting.
- **Requester protocol:**
  - Hold `req` and all fields stable until ack.
  - Re-assert `req` no earlier than the cycle after ack.
  - If `req` drops before ack, the latched access still completes and ack still pulses.
- **Read data:** captured only on reads. On writes, rdata keeps its previous value.

## Timing
- **Latency:** `req` sampled in IDLE at cycle N → ISSUE at N+1 → ack at N+2+`MEM_LAT`. Default is 3 cycles after the request.
- **Throughput:** one access per 3+`MEM_LAT` cycles.
- **Back-to-back:** a request waiting during DONE is considered in the following IDLE cycle.
- **Reset values:**
  - State IDLE; all acks, strobes, `mem_*` address/data, rdata and `burst_cnt` = 0.
  - `last_owner` = E, so C wins the first tie.
- **Reset mid-operation:**
  - At the next edge, the FSM returns to IDLE and the in-flight access is dropped without an ack.
  - A write strobe already issued is not undone.
- **Simultaneous events:**
  - `e_lock` falling in the same cycle as arbitration takes effect immediately; lock is not honoured.
  - A new request arriving during ISSUE, WAIT or DONE only raises stall.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin tie-break. When both ports request without a valid lock, the port that is not `last_owner` wins.
- **`MEM_ARB_RR_EN` undefined:** fixed priority. C always wins ties; the lock and `MAX_BURST` rules are unchanged.

## Structure
- **Package `mem_arb_pkg`:**
  - State encoding: IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3.
  - Owner constants: `OWN_C` = 0, `OWN_E` = 1.
  - Default widths.
- **Sub-module `mem_arb_pick`:**
  - Combinational winner selection from `c_req`, `e_req`, `e_lock`, `last_owner` and `burst_cnt`.
  - Contains the `MEM_ARB_RR_EN` branch.
- **Top level:** FSM, latency counter, burst counter, latch registers and output registers.

## Test plan
- **C read alone:** `c_req=1`, `c_we=0`, `c_addr=0x10`, memory returns `0xDEADBEEF`. Expect `mem_read` high in cycle 1, `c_ack` plus `c_rdata=0xDEADBEEF` in cycle 3, `c_stall` high for cycles 0–2.
- **E write:** `e_we=1`, `e_addr=0x20`, `e_wdata=0x55`. Expect one-cycle `mem_write_en` with those values, `e_ack` 3 cycles after the request, `e_rdata` unchanged.
- **Tie:** both ports request continuously.
  - With `MEM_ARB_RR_EN`: grants alternate C, E, C, E.
  - Without it: C is granted every slot while its request persists.
- **Lock:** `e_lock=1`, both request, `MAX_BURST=4`, E owns first. Expect E granted 4 times, then C, then `burst_cnt=0`.
- **Reset in WAIT:** `reset=1` during WAIT of a C read. Expect no `c_ack`, all outputs 0 next cycle, and the next C request completes normally in 3 cycles.
- **`MEM_LAT=3`:** expect ack 5 cycles after the request and rdata captured on the third WAIT cycle.
